// File: rtl/board_ctrl.sv
// Board controller: input synchronizers, push-button debounce, PLL-lock reset sequencing and LED drive.
// Define BOARD_CTRL_HEARTBEAT_EN to drive the top LED from a free-running heartbeat counter.
module board_ctrl #(
  parameter int NBTN       = 2,
  parameter int NLED       = 8,
  parameter int DEB_CYCLES = 50000,
  parameter int RST_CYCLES = 4096,
  parameter int HB_BITS    = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pll_locked,
  input  logic [NBTN-1:0] btn,
  input  logic [NLED-1:0] led_in,
  output logic            core_reset,
  output logic [NBTN-1:0] btn_db,
  output logic [NBTN-1:0] btn_press,
  output logic [NLED-1:0] led_out
);

  // state     | meaning
  // HOLD      | block reset just released; one idle clock
  // WAIT_LOCK | waiting for synced PLL lock with the reset button released
  // COUNT     | lock seen; counting RST_CYCLES clocks before releasing the core
  // RUN       | core out of reset
  typedef enum logic [1:0] {HOLD, WAIT_LOCK, COUNT, RUN} state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  logic            lock_m, lock_s;
  logic [NBTN-1:0] btn_m, btn_s;
  logic [DW-1:0]   deb_cnt [NBTN];
  state_t          state;
  logic [RW-1:0]   hold_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      btn_m  <= '1;
      btn_s  <= '1;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      btn_m  <= btn;
      btn_s  <= btn_m;
    end
  end

  // Counter restarts whenever the synced (inverted) level agrees with the debounced state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_db    <= '0;
      btn_press <= '0;
      for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      btn_press <= '0;
      for (int i = 0; i < NBTN; i++) begin
        if (!btn_s[i] == btn_db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]   <= '0;
          btn_db[i]    <= !btn_db[i];
          btn_press[i] <= !btn_db[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      case (state)
        HOLD: state <= WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s && !btn_db[0]) begin
            state    <= COUNT;
            hold_cnt <= '0;
          end
        end
        COUNT: begin
          if (!lock_s || btn_db[0]) begin
            state <= WAIT_LOCK;
          end else if (hold_cnt == RST_LAST) begin
            state <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s || btn_press[0]) state <= WAIT_LOCK;
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign core_reset = (state != RUN);

`ifdef BOARD_CTRL_HEARTBEAT_EN
  logic [NLED-2:0]    led_q;
  logic [HB_BITS-1:0] hb_cnt;

  always_ff @(posedge clk) begin
    if (!reset) led_q <= '0;
    else        led_q <= led_in[NLED-2:0];
  end

  always_ff @(posedge clk) begin
    if (!reset || core_reset) hb_cnt <= '0;
    else                      hb_cnt <= hb_cnt + 1'b1;
  end

  assign led_out = core_reset ? '0 : {hb_cnt[HB_BITS-1], led_q};
`else
  logic [NLED-1:0] led_q;

  always_ff @(posedge clk) begin
    if (!reset) led_q <= '0;
    else        led_q <= led_in;
  end

  // Mask on the live state so LEDs go dark the same cycle the core enters reset.
  assign led_out = core_reset ? '0 : led_q;
`endif

endmodule
